request_queue: RTL
==================

REQUEST_QUEUE -- requirements
Module: request_queue

Interface
REQ-001 Parameter DEPTH, default global_defs::DEPTH (16), number of queue entries; SHALL be a power of two ≥2.
REQ-002 Parameter AGE_LIMIT, default 100, head life value (0..127) at or above which the head is flagged aged.
REQ-003 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 in_req  in  parser_out_struct  parser output; in_req.op_ready_s is the push request.
REQ-006 out_req  out  parser_out_struct  head entry; out_req.op_ready_s SHALL equal out_valid.
REQ-007 out_valid  out  1  head entry present.
REQ-008 out_ready  in  1  scheduler accepts head this cycle.
REQ-009 out_bank_group  out  2  head address bits [7:6].
REQ-010 out_bank  out  2  head address bits [9:8].
REQ-011 out_column  out  8  head address bits [17:10].
REQ-012 out_row  out  10  head address bits [27:18].
REQ-013 count  out  $clog2(DEPTH)+1  entries held.
REQ-014 full  out  1  count == DEPTH.
REQ-015 empty  out  1  count == 0.
REQ-016 aged  out  1  out_valid and head life ≥ AGE_LIMIT.
REQ-017 overflow  out  1  sticky: a push was rejected because the queue was full.

Function
REQ-018 Push SHALL occur when in_req.op_ready_s=1, in_req.opcode≠NOP and full=0 (full sampled before any same-cycle pop).
REQ-019 A pushed entry SHALL store CPU_clock_count, opcode and address unchanged, with life forced to 0.
REQ-020 Pop SHALL occur when out_valid=1 and out_ready=1; out_ready while empty SHALL be ignored.
REQ-021 Simultaneous push and pop while not full SHALL leave count unchanged and advance both pointers.
REQ-022 Push while full SHALL be dropped, even with a same-cycle pop, and SHALL set overflow; the pop still completes.
REQ-023 Push of opcode NOP SHALL be ignored silently (no overflow, no count change).
REQ-024 Latency: a push into an empty queue SHALL make out_valid=1 on the following cycle; no same-cycle bypass.
REQ-025 Head outputs SHALL come from registered storage and the read pointer, with no combinational path from in_req to out_*.
REQ-026 Each cycle, life of every occupied entry SHALL increment by 1, saturating at 127; the entry pushed that cycle starts at 0.
REQ-027 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-028 count SHALL be maintained as a separate register, not derived from the pointers.
REQ-029 Occupancy states EMPTY→PARTIAL on push; PARTIAL→FULL when count reaches DEPTH; FULL→PARTIAL on pop; PARTIAL→EMPTY when count reaches 0; DEPTH=2 SHALL follow the same rules.
REQ-030 When out_valid=0, out_req SHALL show opcode=NOP, address 0, life 0 and op_ready_s 0, and out_bank_group, out_bank, out_column and out_row SHALL be 0.

Reset
REQ-031 reset_n low SHALL asynchronously clear pointers, count, overflow and all entry life/valid state.
REQ-032 Reset values SHALL be: out_valid 0, empty 1, full 0, count 0, aged 0, overflow 0, and address fields 0.
REQ-033 Reset asserted mid-operation SHALL discard all entries; the first push after deassertion SHALL be the head.

Structure
REQ-034 DEPTH, parser_out_struct, parsed_op_t, the *_OFFSET constants and the address masks SHALL come from package global_defs; no local redefinitions.
REQ-035 The address field split SHALL be a sub-module addr_decode (combinational, address in, bank_group/bank/column/row out), reusable by the scheduler.
REQ-036 Storage SHALL be a register array of parser_out_struct plus a per-entry valid bit.

Verification
REQ-037 Reset, push READ at 0x0003_4A5C, pop next cycle -> out_valid=1 one cycle after push; bank_group=1, bank=2, column=0xD2, row=0x0 (address bits [27:18] = 0x0).
REQ-038 Push 16 writes with out_ready=0 -> full=1, count=16; 17th push -> overflow=1, count=16; pops return all 16 in order.
REQ-039 Full queue, push and out_ready=1 in the same cycle -> pop completes, push is dropped, count=15, overflow=1.
REQ-040 Push one entry, hold out_ready=0 for 130 cycles -> life reaches 100 and aged=1, then life saturates at 127.
REQ-041 Push with opcode=NOP -> count unchanged, overflow=0; drive out_ready=1 while empty -> count stays 0.
REQ-042 Hold 5 entries, pulse reset_n low mid-cycle -> outputs clear immediately; next push is the head with life=0.

Source files
------------

// File: rtl/global_defs.sv
// -----------------------------------------------------------------------------
// global_defs
// Definitions shared by the parser, the request queue and the scheduler:
// queue depth, the DRAM address field layout (offsets and masks), the parsed
// opcode enum and the parser_out_struct record that flows between blocks.
// It also holds the queue occupancy enum and a saturating life-increment helper.
// No ports (package).
// -----------------------------------------------------------------------------
package global_defs;

   localparam int DEPTH  = 32'd16;
   localparam int ADDR_W = 32'd32;
   localparam int LIFE_W = 32'd7;

   localparam logic [LIFE_W-1:0] LIFE_MAX = 7'd127;

   // DRAM address field placement
   localparam int BANK_GROUP_OFFSET = 32'd6;
   localparam int BANK_OFFSET       = 32'd8;
   localparam int COLUMN_OFFSET     = 32'd10;
   localparam int ROW_OFFSET        = 32'd18;

   localparam logic [ADDR_W-1:0] BANK_GROUP_MASK = 32'h0000_00C0;
   localparam logic [ADDR_W-1:0] BANK_MASK       = 32'h0000_0300;
   localparam logic [ADDR_W-1:0] COLUMN_MASK     = 32'h0003_FC00;
   localparam logic [ADDR_W-1:0] ROW_MASK        = 32'h0FFC_0000;

   typedef enum logic [2:0] {
      NOP       = 3'd0,
      READ      = 3'd1,
      WRITE     = 3'd2,
      ACTIVATE  = 3'd3,
      PRECHARGE = 3'd4,
      REFRESH   = 3'd5
   } parsed_op_t;

   typedef struct packed {
      logic [31:0]       CPU_clock_count;
      parsed_op_t        opcode;
      logic [ADDR_W-1:0] address;
      logic [LIFE_W-1:0] life;
      logic              op_ready_s;
   } parser_out_struct;

   localparam parser_out_struct PARSER_IDLE = '{
      CPU_clock_count: 32'd0,
      opcode:          NOP,
      address:         32'd0,
      life:            7'd0,
      op_ready_s:      1'b0
   };

   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_state_t;

   // Age counter that sticks at its maximum instead of wrapping
   function automatic logic [LIFE_W-1:0] life_inc(input logic [LIFE_W-1:0] life);
      if (life == LIFE_MAX) begin
         return life;
      end else begin
         return life + 7'd1;
      end
   endfunction

endpackage

// File: rtl/addr_decode.sv
// -----------------------------------------------------------------------------
// addr_decode
// Combinational split of a DRAM request address into its bank group, bank,
// column and row fields. Shared by the request queue and the scheduler.
// Ports:
//   address    in  ADDR_W  request address
//   bank_group out 2       address bits [7:6]
//   bank       out 2       address bits [9:8]
//   column     out 8       address bits [17:10]
//   row        out 10      address bits [27:18]
// -----------------------------------------------------------------------------
module addr_decode
   import global_defs::*;
(
   input  logic [ADDR_W-1:0] address,
   output logic [1:0]        bank_group,
   output logic [1:0]        bank,
   output logic [7:0]        column,
   output logic [9:0]        row
);

   logic [ADDR_W-1:0] bg_full_s;
   logic [ADDR_W-1:0] bank_full_s;
   logic [ADDR_W-1:0] col_full_s;
   logic [ADDR_W-1:0] row_full_s;
   logic              unused_s;

   assign bg_full_s   = (address & BANK_GROUP_MASK) >> BANK_GROUP_OFFSET;
   assign bank_full_s = (address & BANK_MASK)       >> BANK_OFFSET;
   assign col_full_s  = (address & COLUMN_MASK)     >> COLUMN_OFFSET;
   assign row_full_s  = (address & ROW_MASK)        >> ROW_OFFSET;

   assign bank_group = bg_full_s[1:0];
   assign bank       = bank_full_s[1:0];
   assign column     = col_full_s[7:0];
   assign row        = row_full_s[9:0];

   // Upper bits are always zero after masking and shifting
   assign unused_s = ^{bg_full_s[ADDR_W-1:2], bank_full_s[ADDR_W-1:2],
                       col_full_s[ADDR_W-1:8], row_full_s[ADDR_W-1:10]};

endmodule

// File: rtl/request_queue.sv
// -----------------------------------------------------------------------------
// request_queue
// In-order FIFO of parsed DRAM requests between the parser and the scheduler.
// Every held entry ages by one per cycle (saturating), and the head is flagged
// when its age reaches AGE_LIMIT. Pushes into a full queue are dropped and
// latched in a sticky overflow flag.
// Ports:
//   clock, reset_n         clock, asynchronous active-low reset
//   in_req                 parser output; op_ready_s requests a push
//   out_req, out_valid     head entry and its presence
//   out_ready              scheduler takes the head this cycle
//   out_bank_group/bank/column/row  head address fields
//   count, full, empty     occupancy
//   aged                   head age at or above AGE_LIMIT
//   overflow               sticky dropped-push flag
// -----------------------------------------------------------------------------
module request_queue
   import global_defs::*;
#(
   parameter int DEPTH     = global_defs::DEPTH,
   parameter int AGE_LIMIT = 32'd100
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  parser_out_struct       in_req,
   output parser_out_struct       out_req,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [1:0]             out_bank_group,
   output logic [1:0]             out_bank,
   output logic [7:0]             out_column,
   output logic [9:0]             out_row,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty,
   output logic                   aged,
   output logic                   overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 32'd1;
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
   localparam logic [LIFE_W-1:0] AGE_LIM  = LIFE_W'(AGE_LIMIT);

   parser_out_struct mem_q [DEPTH];
   parser_out_struct mem_d [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   occ_state_t       occ_q, occ_d;

   logic             push_req_s;
   logic             push_s;
   logic             pop_s;
   logic             head_valid_s;
   parser_out_struct head_s;

   assign head_valid_s = vld_q[rd_ptr_q];
   // Full is taken from registered state, so a same-cycle pop never frees room
   assign push_req_s   = in_req.op_ready_s && (in_req.opcode != NOP);
   assign push_s       = push_req_s && (occ_q != OCC_FULL);
   assign pop_s        = head_valid_s && out_ready;

   // Entry storage next-state: write at wr_ptr, retire at rd_ptr, age the rest
   always_comb begin
      mem_d = mem_q;
      vld_d = vld_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (push_s && (wr_ptr_q == PTR_W'(i))) begin
            mem_d[i]            = in_req;
            mem_d[i].life       = 7'd0;
            mem_d[i].op_ready_s = 1'b1;
            vld_d[i]            = 1'b1;
         end else if (pop_s && (rd_ptr_q == PTR_W'(i))) begin
            mem_d[i]      = mem_q[i];
            mem_d[i].life = 7'd0;
            vld_d[i]      = 1'b0;
         end else if (vld_q[i]) begin
            mem_d[i]      = mem_q[i];
            mem_d[i].life = life_inc(mem_q[i].life);
            vld_d[i]      = 1'b1;
         end else begin
            mem_d[i] = mem_q[i];
            vld_d[i] = vld_q[i];
         end
      end
   end

   // Pointer, count, overflow and occupancy-state next-state
   always_comb begin
      rd_ptr_d   = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      wr_ptr_d   = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      overflow_d = overflow_q | (push_req_s & (occ_q == OCC_FULL));
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      case (occ_q)
         OCC_EMPTY: begin
            if (push_s) begin
               occ_d = OCC_PARTIAL;
            end else begin
               occ_d = OCC_EMPTY;
            end
         end
         OCC_PARTIAL: begin
            if (count_d == CNT_W'(0)) begin
               occ_d = OCC_EMPTY;
            end else if (count_d == CNT_FULL) begin
               occ_d = OCC_FULL;
            end else begin
               occ_d = OCC_PARTIAL;
            end
         end
         OCC_FULL: begin
            if (pop_s) begin
               occ_d = OCC_PARTIAL;
            end else begin
               occ_d = OCC_FULL;
            end
         end
         default: occ_d = OCC_EMPTY;
      endcase
   end

   // State registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= PARSER_IDLE;
         end
         vld_q      <= {DEPTH{1'b0}};
         rd_ptr_q   <= {PTR_W{1'b0}};
         wr_ptr_q   <= {PTR_W{1'b0}};
         count_q    <= {CNT_W{1'b0}};
         overflow_q <= 1'b0;
         occ_q      <= OCC_EMPTY;
      end else begin
         mem_q      <= mem_d;
         vld_q      <= vld_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         occ_q      <= occ_d;
      end
   end

   // Head view: idle record whenever the queue holds nothing
   always_comb begin
      head_s = PARSER_IDLE;
      if (head_valid_s) begin
         head_s            = mem_q[rd_ptr_q];
         head_s.op_ready_s = 1'b1;
      end else begin
         head_s = PARSER_IDLE;
      end
   end

   assign out_req   = head_s;
   assign out_valid = head_valid_s;
   assign count     = count_q;
   assign full      = (occ_q == OCC_FULL);
   assign empty     = (occ_q == OCC_EMPTY);
   assign aged      = head_valid_s && (head_s.life >= AGE_LIM);
   assign overflow  = overflow_q;

   addr_decode u_addr_decode (
      .address    (head_s.address),
      .bank_group (out_bank_group),
      .bank       (out_bank),
      .column     (out_column),
      .row        (out_row)
   );

endmodule
